calculator_alu: RTL
===================

CALCULATOR_ALU -- requirements
Module: calculator_alu

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, operand/result width in bits (even, >=4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_alu_input_a  input  DATA_WIDTH  operand A (dividend/minuend).
REQ-005 i_alu_input_b  input  DATA_WIDTH  operand B (divisor/subtrahend).
REQ-006 i_alu_input_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-007 i_alu_input_signed  input  1  1: operands are two's complement; 0: unsigned.
REQ-008 i_alu_input_valid  input  1  operand set valid.
REQ-009 o_alu_input_ready  output  1  block can accept an operand set.
REQ-010 o_alu_result  output  DATA_WIDTH  result, low DATA_WIDTH bits.
REQ-011 o_alu_error  output  1  error flag qualified by o_alu_result_valid.
REQ-012 o_alu_result_valid  output  1  result/error valid.
REQ-013 i_alu_result_ready  input  1  consumer accepts result.

Function
REQ-014 FSM states IDLE, CALC, DONE; the block SHALL hold at most one operation in flight.
REQ-015 IDLE: o_alu_input_ready=1; on valid&&ready, latch a, b, op, signed; ADD/SUB/DIV-by-zero go to DONE, MUL/DIV (b!=0) go to CALC.
REQ-016 CALC and DONE: o_alu_input_ready=0; i_alu_input_* ignored.
REQ-017 ADD/SUB: modulo-2^DATA_WIDTH result; o_alu_result_valid first high the cycle after input handshake.
REQ-018 MUL: iterative shift-add on operand magnitudes, one bit per cycle, DATA_WIDTH iterations, then sign fixup (negate if signed and signs differ); result = low DATA_WIDTH bits.
REQ-019 DIV: restoring divide on magnitudes, one quotient bit per cycle, DATA_WIDTH iterations, sign fixup; quotient truncated toward zero; remainder discarded.
REQ-020 MUL/DIV latency: o_alu_result_valid first high exactly DATA_WIDTH+1 cycles after the input handshake cycle.
REQ-021 DIV with b==0: o_alu_error=1, o_alu_result=0, latency as ADD/SUB.
REQ-022 Signed DIV of most-negative by -1: result = most-negative value (wrap); error per REQ-031.
REQ-023 DONE: o_alu_result_valid=1; o_alu_result and o_alu_error SHALL stay stable until i_alu_result_ready=1.
REQ-024 On valid&&ready in DONE, return to IDLE next cycle; new input accepted no earlier than the cycle after result handshake.
REQ-025 i_alu_result_ready may be high before o_alu_result_valid; it SHALL not cause a handshake until valid is high.
REQ-026 Unsigned mode: operands treated as 0..2^DATA_WIDTH-1 for all ops; ADD/SUB bit-identical to signed mode.

Reset
REQ-027 With rst_n=0 at a rising edge: state=IDLE, o_alu_input_ready=1 the following cycle, o_alu_result=0, o_alu_error=0, o_alu_result_valid=0.
REQ-028 Reset asserted in CALC or DONE SHALL abandon the operation; no result is delivered.
REQ-029 While rst_n=0, o_alu_input_ready=0 is permitted; no handshake SHALL occur.

Configuration
REQ-030 Macro CALC_ALU_OVERFLOW_EN selects overflow reporting.
REQ-031 Defined: o_alu_error=1 additionally on signed ADD/SUB overflow, unsigned carry-out (ADD) or borrow (SUB), MUL product not representable in DATA_WIDTH (signed or unsigned range per mode), signed most-negative/-1 DIV; o_alu_result still carries the wrapped value.
REQ-032 Undefined: o_alu_error=1 only for DIV by zero; all other results wrap silently; overflow logic absent.

Verification
REQ-033 Signed MUL a=0xFFFD(-3), b=0x0007 -> result 0xFFEB, error 0, valid 17 cycles after handshake.
REQ-034 DIV signed a=0xFFF9(-7), b=0x0002 -> 0xFFFD; same operands unsigned -> 0x7FFC; both error 0.
REQ-035 DIV a=0x1234, b=0x0000 -> result 0x0000, error 1, valid 1 cycle after handshake.
REQ-036 Signed ADD 0x7FFF+0x0001 -> result 0x8000; error 1 with CALC_ALU_OVERFLOW_EN, 0 without.
REQ-037 ADD 5+3 with i_alu_result_ready held 0 for 10 cycles -> result 0x0008 stable, input_ready 0 throughout; ready=1 -> IDLE, next input accepted following cycle.
REQ-038 MUL started, rst_n=0 at iteration 8 -> no result_valid ever; outputs per REQ-027; next ADD completes normally.

Source files
------------

// File: rtl/calculator_alu.sv
// Multi-cycle integer ALU: single-cycle ADD/SUB, iterative shift-add MUL and restoring DIV.
// Define CALC_ALU_OVERFLOW_EN to report overflow/carry/borrow on o_alu_error as well as divide-by-zero.
module calculator_alu #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_alu_input_a,
  input  logic [DATA_WIDTH-1:0] i_alu_input_b,
  input  logic [1:0]            i_alu_input_op,
  input  logic                  i_alu_input_signed,
  input  logic                  i_alu_input_valid,
  output logic                  o_alu_input_ready,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic                  o_alu_error,
  output logic                  o_alu_result_valid,
  input  logic                  i_alu_result_ready
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_t;

  state_t          state_q, state_d;
  logic            accept, go_calc, last, b_zero;
  op_t             op_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  mcand_q, prod_q, prod_nxt;
  logic [W-1:0]    mplier_q, dvsr_q, quot_q, rem_q, quot_nxt, rem_nxt;
  logic [W:0]      shifted, rdiff;
  logic [W-1:0]    mag_res, calc_res, res_q;
  logic            err_q;
  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag, sum, diff;
  logic            add_ovf, sub_ovf, calc_ovf;

  // No handshake can happen while reset is held.
  assign accept  = (state_q == IDLE) && rst_n && i_alu_input_valid;
  assign b_zero  = (i_alu_input_b == '0);
  assign go_calc = (i_alu_input_op == OP_MUL) || ((i_alu_input_op == OP_DIV) && !b_zero);
  assign last    = (cnt_q == CW'(W - 1));

  assign o_alu_result = res_q;
  assign o_alu_error  = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d            = state_q;
    o_alu_input_ready  = 1'b0;
    o_alu_result_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_alu_input_ready = rst_n;
        if (accept) state_d = go_calc ? CALC : DONE;
      end
      CALC: if (last) state_d = DONE;
      DONE: begin
        o_alu_result_valid = 1'b1;
        if (i_alu_result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_neg    = i_alu_input_signed & i_alu_input_a[W-1];
    b_neg    = i_alu_input_signed & i_alu_input_b[W-1];
    a_mag    = a_neg ? ('0 - i_alu_input_a) : i_alu_input_a;
    b_mag    = b_neg ? ('0 - i_alu_input_b) : i_alu_input_b;
    sum      = i_alu_input_a + i_alu_input_b;
    diff     = i_alu_input_a - i_alu_input_b;
    prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
    // Restoring step: the borrow out of the trial subtraction decides the quotient bit.
    shifted  = {rem_q, quot_q[W-1]};
    rdiff    = shifted - {1'b0, dvsr_q};
    rem_nxt  = rdiff[W] ? shifted[W-1:0] : rdiff[W-1:0];
    quot_nxt = {quot_q[W-2:0], ~rdiff[W]};
    mag_res  = (op_q == OP_MUL) ? prod_nxt[W-1:0] : quot_nxt;
    calc_res = neg_q ? ('0 - mag_res) : mag_res;
  end

  // NOTE: the iteration registers are always loaded on accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= op_t'(i_alu_input_op);
      neg_q    <= i_alu_input_signed & (i_alu_input_a[W-1] ^ i_alu_input_b[W-1]);
      mcand_q  <= {{W{1'b0}}, a_mag};
      mplier_q <= b_mag;
      prod_q   <= '0;
      dvsr_q   <= b_mag;
      quot_q   <= a_mag;
      rem_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == CALC) begin
      cnt_q    <= cnt_q + CW'(1);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      prod_q   <= prod_nxt;
      quot_q   <= quot_nxt;
      rem_q    <= rem_nxt;
    end
  end

  // Result registers are written once per operation and hold through DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else if (accept && !go_calc) begin
      case (i_alu_input_op)
        OP_ADD:  begin res_q <= sum;  err_q <= add_ovf; end
        OP_SUB:  begin res_q <= diff; err_q <= sub_ovf; end
        default: begin res_q <= '0;   err_q <= 1'b1;    end
      endcase
    end else if ((state_q == CALC) && last) begin
      res_q <= calc_res;
      err_q <= calc_ovf;
    end
  end

`ifdef CALC_ALU_OVERFLOW_EN
  localparam logic [2*W-1:0] HALF     = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]   MOST_NEG = {1'b1, {(W-1){1'b0}}};

  logic sgn_q, div_ovf_q, mul_ovf;

  always_ff @(posedge clk) begin
    if (accept) begin
      sgn_q     <= i_alu_input_signed;
      div_ovf_q <= i_alu_input_signed && (i_alu_input_a == MOST_NEG) && (i_alu_input_b == '1);
    end
  end

  // A negative signed product may reach magnitude 2^(W-1); a positive one may not.
  always_comb begin
    add_ovf = i_alu_input_signed
            ? ((i_alu_input_a[W-1] == i_alu_input_b[W-1]) && (sum[W-1] != i_alu_input_a[W-1]))
            : (sum < i_alu_input_a);
    sub_ovf = i_alu_input_signed
            ? ((i_alu_input_a[W-1] != i_alu_input_b[W-1]) && (diff[W-1] != i_alu_input_a[W-1]))
            : (i_alu_input_a < i_alu_input_b);
    if (!sgn_q)     mul_ovf = |prod_nxt[2*W-1:W];
    else if (neg_q) mul_ovf = (prod_nxt > HALF);
    else            mul_ovf = (prod_nxt >= HALF);
    calc_ovf = (op_q == OP_MUL) ? mul_ovf : div_ovf_q;
  end
`else
  assign add_ovf  = 1'b0;
  assign sub_ovf  = 1'b0;
  assign calc_ovf = 1'b0;
`endif

endmodule
